// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC access scheduler: state encoding,
// index width and the fixed index-to-RTC-address map.
package rtc_pkg;

  localparam int unsigned N_ENTRIES = 11;
  localparam int unsigned IDX_W     = 4;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StAccess,
    StComplete
  } state_e;

  localparam logic [7:0] ADDR_IDX0  = 8'h00;
  localparam logic [7:0] ADDR_IDX1  = 8'h64;
  localparam logic [7:0] ADDR_IDX2  = 8'h65;
  localparam logic [7:0] ADDR_IDX3  = 8'h66;
  localparam logic [7:0] ADDR_IDX4  = 8'h67;
  localparam logic [7:0] ADDR_IDX5  = 8'h33;
  localparam logic [7:0] ADDR_IDX6  = 8'h34;
  localparam logic [7:0] ADDR_IDX7  = 8'h35;
  localparam logic [7:0] ADDR_IDX8  = 8'h36;
  localparam logic [7:0] ADDR_IDX9  = 8'h37;
  localparam logic [7:0] ADDR_IDX10 = 8'h38;

  localparam idx_t SWEEP_FIRST = 4'd1;
  localparam idx_t SWEEP_LAST  = 4'd10;

  function automatic logic [7:0] idx_to_addr(input idx_t idx);
    logic [7:0] addr;
    case (idx)
      4'd0:    addr = ADDR_IDX0;
      4'd1:    addr = ADDR_IDX1;
      4'd2:    addr = ADDR_IDX2;
      4'd3:    addr = ADDR_IDX3;
      4'd4:    addr = ADDR_IDX4;
      4'd5:    addr = ADDR_IDX5;
      4'd6:    addr = ADDR_IDX6;
      4'd7:    addr = ADDR_IDX7;
      4'd8:    addr = ADDR_IDX8;
      4'd9:    addr = ADDR_IDX9;
      4'd10:   addr = ADDR_IDX10;
      default: addr = 8'h00;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/rtc_access_scheduler_if.sv
// User-side request/result signals and the RTC req/ack bus, bundled for the scheduler.
interface rtc_access_scheduler_if;
  import rtc_pkg::*;

  logic       tick;
  logic       wr_req;
  idx_t       wr_idx;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       wr_done;
  logic       err;
  idx_t       rd_idx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       sweep_done;
  logic       busy;
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;

  modport slave (
    input  tick, wr_req, wr_idx, wr_data, bus_ack, bus_rdata,
    output wr_ready, wr_done, err, rd_idx, rd_data, rd_valid, sweep_done, busy,
    output bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output tick, wr_req, wr_idx, wr_data, bus_ack, bus_rdata,
    input  wr_ready, wr_done, err, rd_idx, rd_data, rd_valid, sweep_done, busy,
    input  bus_req, bus_we, bus_addr, bus_wdata
  );

endinterface

// File: rtl/rtc_addr_lut.sv
// Registered index-to-RTC-address lookup; one cycle of latency, unknown indices map to 00.
module rtc_addr_lut
  import rtc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  idx_t       idx_i,
  output logic [7:0] addr_o
);

  logic [7:0] addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= 8'h00;
    end else begin
      addr_q <= idx_to_addr(idx_i);
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/rtc_access_scheduler.sv
// Sequences RTC bus accesses: periodic read sweep of indices 1..10 with user writes
// slotted in between transactions, one req/ack transaction at a time.
module rtc_access_scheduler
  import rtc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rtc_access_scheduler_if.slave sched_io
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  idx_t            cur_idx_q, cur_idx_d;
  idx_t            txn_idx_q, txn_idx_d;
  logic            txn_we_q, txn_we_d;
  logic            sweep_pend_q, sweep_pend_d;
  logic            wr_pend_q, wr_pend_d;
  idx_t            wr_idx_q, wr_idx_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [7:0]      bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  idx_t            rd_idx_q, rd_idx_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d, wr_done_q, wr_done_d;
  logic            err_q, err_d, sweep_done_q, sweep_done_d;
  logic            dispatch;
  logic            txn_end;
  logic [7:0]      lut_addr;

  // Table lookup is driven by the index being dispatched so the address is ready in LOOKUP.
  rtc_addr_lut u_addr_lut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .idx_i  (txn_idx_d),
    .addr_o (lut_addr)
  );

  always_comb begin
    state_d      = state_q;
    cur_idx_d    = cur_idx_q;
    txn_idx_d    = txn_idx_q;
    txn_we_d     = txn_we_q;
    wr_pend_d    = wr_pend_q;
    wr_idx_d     = wr_idx_q;
    wr_data_d    = wr_data_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    rd_idx_d     = rd_idx_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    wr_done_d    = 1'b0;
    err_d        = 1'b0;
    sweep_done_d = 1'b0;
    dispatch     = 1'b0;
    txn_end      = 1'b0;
    sweep_pend_d = sweep_pend_q | sched_io.tick;

    if (sched_io.wr_req && !wr_pend_q) begin
      if (sched_io.wr_idx > idx_t'(N_ENTRIES - 1)) begin
        err_d     = 1'b1;
        wr_done_d = 1'b1;
      end else begin
        wr_pend_d = 1'b1;
        wr_idx_d  = sched_io.wr_idx;
        wr_data_d = sched_io.wr_data;
      end
    end

    case (state_q)
      StIdle, StComplete: dispatch = 1'b1;
      StLookup: begin
        state_d     = StAccess;
        bus_req_d   = 1'b1;
        bus_we_d    = txn_we_q;
        bus_addr_d  = lut_addr;
        bus_wdata_d = txn_we_q ? wr_data_q : 8'h00;
        cnt_d       = '0;
      end
      StAccess: begin
        if (sched_io.bus_ack || cnt_q == CntW'(TIMEOUT - 1)) begin
          txn_end   = 1'b1;
          state_d   = StComplete;
          bus_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Result pulses and progress are registered on the ACCESS exit, so they show during COMPLETE
    // and COMPLETE dispatches from already-updated pending flags.
    if (txn_end) begin
      if (txn_we_q) begin
        wr_done_d = 1'b1;
        wr_pend_d = 1'b0;
        err_d     = err_d | !sched_io.bus_ack;
      end else begin
        if (sched_io.bus_ack) begin
          rd_valid_d = 1'b1;
          rd_idx_d   = txn_idx_q;
          rd_data_d  = sched_io.bus_rdata;
        end else begin
          err_d = 1'b1;
        end
        if (txn_idx_q == SWEEP_LAST) begin
          cur_idx_d    = SWEEP_FIRST;
          sweep_pend_d = 1'b0;
          sweep_done_d = 1'b1;
        end else begin
          cur_idx_d = txn_idx_q + idx_t'(1);
        end
      end
    end

    if (dispatch) begin
      if (wr_pend_q) begin
        state_d   = StLookup;
        txn_we_d  = 1'b1;
        txn_idx_d = wr_idx_q;
      end else if (sweep_pend_q) begin
        state_d   = StLookup;
        txn_we_d  = 1'b0;
        txn_idx_d = cur_idx_q;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cur_idx_q    <= SWEEP_FIRST;
      txn_idx_q    <= '0;
      txn_we_q     <= 1'b0;
      sweep_pend_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      wr_idx_q     <= '0;
      wr_data_q    <= 8'h00;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 8'h00;
      bus_wdata_q  <= 8'h00;
      rd_idx_q     <= '0;
      rd_data_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
      wr_done_q    <= 1'b0;
      err_q        <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_idx_q    <= cur_idx_d;
      txn_idx_q    <= txn_idx_d;
      txn_we_q     <= txn_we_d;
      sweep_pend_q <= sweep_pend_d;
      wr_pend_q    <= wr_pend_d;
      wr_idx_q     <= wr_idx_d;
      wr_data_q    <= wr_data_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      rd_idx_q     <= rd_idx_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      wr_done_q    <= wr_done_d;
      err_q        <= err_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign sched_io.wr_ready   = !wr_pend_q;
  assign sched_io.wr_done    = wr_done_q;
  assign sched_io.err        = err_q;
  assign sched_io.rd_idx     = rd_idx_q;
  assign sched_io.rd_data    = rd_data_q;
  assign sched_io.rd_valid   = rd_valid_q;
  assign sched_io.sweep_done = sweep_done_q;
  assign sched_io.busy       = (state_q != StIdle);
  assign sched_io.bus_req    = bus_req_q;
  assign sched_io.bus_we     = bus_we_q;
  assign sched_io.bus_addr   = bus_addr_q;
  assign sched_io.bus_wdata  = bus_wdata_q;

endmodule

// File: doc/rtc_access_scheduler.md
# rtc_access_scheduler

Sequences all accesses to the RTC register bus. Owns the 11-entry index-to-address map and runs a periodic read sweep of RTC indices 1–10 on each refresh tick. Arbitrates user write requests into the gaps between sweep transactions and drives the req/ack bus driver one transaction at a time. Sits between the display/edit logic and the RTC bus interface.

## Interface
- N_ENTRIES, 11: number of table entries (indices 0..10).
- TIMEOUT, 255: cycles to wait for `bus_ack` before a transaction is aborted.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle refresh request; starts a read sweep.
- wr_req  in  1  user write request; sampled only when `wr_ready`=1.
- wr_idx  in  4  table index to write.
- wr_data  in  8  write data.
- wr_ready  out  1  high when no write is pending.
- wr_done  out  1  one-cycle pulse when a write completes or aborts.
- err  out  1  one-cycle pulse on timeout or rejected index.
- rd_idx  out  4  index of the captured read.
- rd_data  out  8  captured read data.
- rd_valid  out  1  one-cycle pulse; `rd_idx`/`rd_data` are valid.
- sweep_done  out  1  one-cycle pulse after index 10 completes.
- busy  out  1  high in any state other than IDLE.
- bus_req, bus_we  out  1  transaction request and direction (1 = write).
- bus_addr, bus_wdata  out  8  RTC address and write data.
- bus_ack  in  1  one-cycle acknowledge.
- bus_rdata  in  8  read data, valid in the `bus_ack` cycle.

## Operation
- Address map: 0→00, 1→64, 2→65, 3→66, 4→67, 5→33, 6→34, 7→35, 8→36, 9→37, 10→38 (hex).
- Pending flags:
  - `tick` sets `sweep_pend`. A tick that arrives while a sweep is pending or active is merged and produces no extra sweep.
  - An accepted `wr_req` latches `wr_idx`/`wr_data` and sets `wr_pend`, which drops `wr_ready`.
- Write index check: `wr_idx` > 10 is rejected at acceptance. `err` and `wr_done` pulse on the next cycle, and no bus transaction is issued.
- FSM states are IDLE, LOOKUP, ACCESS and COMPLETE.
  - IDLE: if a write is pending, go to LOOKUP with the write. Otherwise, if a sweep is pending, go to LOOKUP with the current sweep index (cur_idx), which starts at 1.
  - LOOKUP: one cycle for the registered table read.
  - ACCESS: `bus_req` is high and `bus_addr`/`bus_we`/`bus_wdata` are held stable. On `bus_ack`, capture `bus_rdata` and go to COMPLETE. If `TIMEOUT` cycles pass with no ack, go to COMPLETE with an abort.
  - COMPLETE: drop `bus_req` and pulse the result.
    - Read: pulse `rd_valid`. On abort, pulse `err` instead of `rd_valid`.
    - Write: pulse `wr_done`, plus `err` on abort.
- Arbitration point: COMPLETE and IDLE only. A pending write beats the next sweep entry. The sweep resumes at the saved index and a write never restarts it.
- Sweep progress:
  - After index 10 completes: pulse `sweep_done`, reset cur_idx to 1, clear `sweep_pend`.
  - After any other sweep entry: increment cur_idx.
  - The next state is LOOKUP if work is pending, otherwise IDLE.
- Index 0 is never read by the sweep. It is accessible only by a write.

## Timing
- Reset (asynchronous, immediate): state=IDLE, cur_idx=1, both pending flags clear, every output 0 except `wr_ready`=1. `bus_req` drops mid-transaction; the aborted transaction is not retried.
- Request sampled at edge k in IDLE: LOOKUP at k+1, ACCESS with `bus_req`=1 from k+2.
- `bus_ack` at edge m: COMPLETE from m+1 with `bus_req`=0 and the result pulse. The next transaction reaches ACCESS at m+3.
- Fastest full sweep: 10 × (3 + ack latency) cycles.
- Timeout: with ACCESS entered at edge a and no ack, COMPLETE is entered at edge a+TIMEOUT.
- `tick` and `wr_req` arriving in the same cycle while IDLE: the write is served first.
- An ack outside ACCESS is ignored.

## Structure
- Package `rtc_pkg` holds:
  - `N_ENTRIES` and the index width (4).
  - The state enum.
  - The 11 address constants and the first/last sweep index (1, 10).
- Sub-module `rtc_addr_lut`: registered index→address lookup, one cycle of latency. Out-of-range indices return 00.
- The FSM, pending flags, timeout counter and output registers live in the top module.

## Test plan
- Reset, one `tick`, ack 2 cycles after each `bus_req`, `bus_rdata`=addr+1 → 10 `rd_valid` pulses, idx 1..10, addresses 64,65,66,67,33..38, data 65..39, then one `sweep_done`; `bus_req` never high for address 00.
- `wr_req` idx=3, data=5A during a sweep at index 2 → after index 2 completes, a write to addr 66 with `bus_we`=1 and data 5A, then `wr_done`; the sweep resumes at index 3 (read of 66).
- Same-cycle `tick` + `wr_req` idx=0, data=80 while IDLE → first transaction is a write to 00, then the sweep starts at 64.
- No ack on index 4 → `bus_req` high exactly 255 cycles, `err` pulse, no `rd_valid` for 4, next access to addr 33.
- `wr_req` idx=12 → `err` + `wr_done` next cycle, no `bus_req`, `wr_ready` back to 1.
- `reset` low during ACCESS of index 6 → `bus_req` drops asynchronously; after release and a new `tick`, the sweep restarts at index 1.
